// File: rtl/wb_req_queue_pkg.sv
// Shared types for the writeback request queue: result fields, the
// buffered entry layout, and a width helper for occupancy counters.
package wb_req_queue_pkg;

  typedef logic [4:0]  VRegIdx_t;
  typedef logic [5:0]  RsvID_t;
  typedef logic [63:0] Vector_t;

  typedef struct packed {
    VRegIdx_t vreg;
    RsvID_t   rid;
    Vector_t  data;
  } WbEntry_t;

  // Counter width able to hold every occupancy value 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_req_queue_if.sv
// Execution-unit push side, writeback request side and status of one
// writeback request channel queue.
interface wb_req_queue_if
  import wb_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);

  logic                      inValid;
  logic                      inReady;
  VRegIdx_t                  inVRegIdx;
  RsvID_t                    inRID;
  Vector_t                   inDataVec;

  logic                      req;
  VRegIdx_t                  reqVRegIdx;
  RsvID_t                    reqRID;
  Vector_t                   reqDataVec;
  logic                      stall;

  logic                      almostFull;
  logic [cnt_w(DEPTH)-1:0]   count;

  // Queue side
  modport slave (
    input  inValid, inVRegIdx, inRID, inDataVec, stall,
    output inReady, req, reqVRegIdx, reqRID, reqDataVec, almostFull, count
  );

  // Producer / writeback side
  modport master (
    output inValid, inVRegIdx, inRID, inDataVec, stall,
    input  inReady, req, reqVRegIdx, reqRID, reqDataVec, almostFull, count
  );

endinterface

// File: rtl/wb_req_queue.sv
// Per-channel result FIFO between an execution unit and the writeback
// arbiter. Oldest entry is presented as the request; it retires on any
// cycle the request is not stalled. No empty bypass.
module wb_req_queue
  import wb_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = DEPTH - 1
) (
  input  logic          clk,
  input  logic          rst,
  wb_req_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
  localparam cnt_t AF_CNT   = cnt_t'(AF_THRESH);

  WbEntry_t mem [DEPTH];
  ptr_t     wr_ptr;
  ptr_t     rd_ptr;
  cnt_t     count_q;

  logic     in_ready;
  logic     has_entry;
  logic     push;
  logic     pop;
  WbEntry_t head;

  // Explicit wrap so non-power-of-two depths index only valid slots.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  // Handshake qualification from registered occupancy only
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    has_entry = (count_q != '0);
    push      = bus.inValid && in_ready && !rst;
    pop       = has_entry && !bus.stall;
  end

  // Entry storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{vreg: bus.inVRegIdx, rid: bus.inRID, data: bus.inDataVec};
    end
  end

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head presentation and status outputs
  always_comb begin
    head           = mem[rd_ptr];
    bus.inReady    = in_ready;
    bus.req        = has_entry;
    bus.reqVRegIdx = head.vreg;
    bus.reqRID     = head.rid;
    bus.reqDataVec = head.data;
    bus.almostFull = (count_q >= AF_CNT);
    bus.count      = count_q;
  end

endmodule

// File: tb/tb_wb_req_queue.sv
// Bench for wb_req_queue: a DEPTH=4 and a DEPTH=3 instance, each tracked
// by a queue-based reference model of the FIFO rules.
module tb_wb_req_queue;
  import wb_req_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  WbEntry_t q4[$];
  WbEntry_t q3[$];

  always #5 clk = ~clk;

  wb_req_queue_if #(.DEPTH(4)) bus4 ();
  wb_req_queue_if #(.DEPTH(3)) bus3 ();

  wb_req_queue #(.DEPTH(4), .AF_THRESH(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  wb_req_queue #(.DEPTH(3), .AF_THRESH(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  function automatic WbEntry_t mk(input int unsigned vreg, input int unsigned rid, input Vector_t data);
    WbEntry_t e;
    e.vreg = VRegIdx_t'(vreg);
    e.rid  = RsvID_t'(rid);
    e.data = data;
    return e;
  endfunction

  function automatic Vector_t rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock on the DEPTH=4 channel (DEPTH=3 channel held idle)
  task automatic step4(input logic r, input logic v, input WbEntry_t e, input logic s);
    logic do_push, do_pop;
    rst = r;
    bus4.inValid = v; bus4.inVRegIdx = e.vreg; bus4.inRID = e.rid; bus4.inDataVec = e.data;
    bus4.stall = s;
    bus3.inValid = 1'b0; bus3.stall = 1'b1;
    @(posedge clk);
    do_push = v && (q4.size() < 4);
    do_pop  = (q4.size() != 0) && !s;
    if (r) begin
      q4.delete();
      q3.delete();
    end else begin
      if (do_pop)  void'(q4.pop_front());
      if (do_push) q4.push_back(e);
    end
    @(negedge clk);
  endtask

  // One clock on the DEPTH=3 channel (DEPTH=4 channel held idle)
  task automatic step3(input logic v, input WbEntry_t e, input logic s);
    logic do_push, do_pop;
    rst = 1'b0;
    bus3.inValid = v; bus3.inVRegIdx = e.vreg; bus3.inRID = e.rid; bus3.inDataVec = e.data;
    bus3.stall = s;
    bus4.inValid = 1'b0; bus4.stall = 1'b1;
    @(posedge clk);
    do_push = v && (q3.size() < 3);
    do_pop  = (q3.size() != 0) && !s;
    if (do_pop)  void'(q3.pop_front());
    if (do_push) q3.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    WbEntry_t e;
    step4(1'b1, 1'b0, '0, 1'b1);
    step4(1'b1, 1'b0, '0, 1'b1);
    step4(1'b0, 1'b0, '0, 1'b0);
    total++; if (bus4.count !== 0) begin bad++; $display("FAIL reset_count: got %0d exp 0", bus4.count); end
    total++; if (bus4.req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b exp 0", bus4.req); end
    total++; if (bus4.inReady !== 1'b1) begin bad++; $display("FAIL reset_inReady: got %b exp 1", bus4.inReady); end
    total++; if (bus4.almostFull !== 1'b0) begin bad++; $display("FAIL reset_almostFull: got %b exp 0", bus4.almostFull); end
    total++; if (bus3.count !== 0 || bus3.req !== 1'b0) begin bad++; $display("FAIL reset_dut3: got count %0d req %b exp 0 0", bus3.count, bus3.req); end
    e = mk(5, 2, 64'hA5A5_A5A5_A5A5_A5A5);
    step4(1'b0, 1'b1, e, 1'b0);
    total++; if (bus4.req !== 1'b1) begin bad++; $display("FAIL first_req: got %b exp 1", bus4.req); end
    total++; if (bus4.reqVRegIdx !== 5) begin bad++; $display("FAIL first_vreg: got %0d exp 5", bus4.reqVRegIdx); end
    total++; if (bus4.reqRID !== 2) begin bad++; $display("FAIL first_rid: got %0d exp 2", bus4.reqRID); end
    total++; if (bus4.reqDataVec !== 64'hA5A5_A5A5_A5A5_A5A5) begin bad++; $display("FAIL first_data: got %h exp a5a5a5a5a5a5a5a5", bus4.reqDataVec); end
    step4(1'b0, 1'b0, '0, 1'b0);
    total++; if (bus4.count !== 0 || bus4.req !== 1'b0) begin bad++; $display("FAIL first_retire: got count %0d req %b exp 0 0", bus4.count, bus4.req); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      step4(1'b0, 1'b1, mk(i + 1, i, rnd64()), 1'b1);
      total++; if (bus4.count !== q4.size()) begin bad++; $display("FAIL fill_count: got %0d exp %0d", bus4.count, q4.size()); end
      total++; if (bus4.almostFull !== (q4.size() >= 3)) begin bad++; $display("FAIL fill_almostFull: got %b exp %b at %0d", bus4.almostFull, q4.size() >= 3, q4.size()); end
      total++; if (bus4.inReady !== (q4.size() != 4)) begin bad++; $display("FAIL fill_inReady: got %b exp %b", bus4.inReady, q4.size() != 4); end
    end
    step4(1'b0, 1'b1, mk(7, 9, rnd64()), 1'b1);
    total++; if (bus4.count !== 4 || bus4.inReady !== 1'b0) begin bad++; $display("FAIL fill_overflow: got count %0d inReady %b exp 4 0", bus4.count, bus4.inReady); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus4.req !== 1'b1 || bus4.reqRID !== i) begin bad++; $display("FAIL drain_order: got req %b rid %0d exp 1 %0d", bus4.req, bus4.reqRID, i); end
      total++; if (bus4.reqDataVec !== q4[0].data) begin bad++; $display("FAIL drain_data: got %h exp %h", bus4.reqDataVec, q4[0].data); end
      step4(1'b0, 1'b0, '0, 1'b0);
    end
    total++; if (bus4.req !== 1'b0 || bus4.count !== 0) begin bad++; $display("FAIL drain_empty: got req %b count %0d exp 0 0", bus4.req, bus4.count); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 20; i++) begin
      step4(1'b0, 1'b1, mk(i, 20 + i, rnd64()), 1'b0);
      total++; if (bus4.count !== 1) begin bad++; $display("FAIL stream_count: got %0d exp 1", bus4.count); end
      total++; if (bus4.req !== 1'b1 || bus4.reqRID !== RsvID_t'(20 + i)) begin bad++; $display("FAIL stream_rid: got req %b rid %0d exp 1 %0d", bus4.req, bus4.reqRID, 20 + i); end
      total++; if (bus4.reqDataVec !== q4[0].data) begin bad++; $display("FAIL stream_data: got %h exp %h", bus4.reqDataVec, q4[0].data); end
    end
    step4(1'b0, 1'b0, '0, 1'b0);
    total++; if (bus4.count !== 0) begin bad++; $display("FAIL stream_tail: got %0d exp 0", bus4.count); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) step4(1'b0, 1'b1, mk(3, 10 + i, rnd64()), 1'b1);
    total++; if (bus4.count !== 4) begin bad++; $display("FAIL fullpop_pre: got %0d exp 4", bus4.count); end
    step4(1'b0, 1'b1, mk(3, 30, rnd64()), 1'b0);
    total++; if (bus4.count !== 3) begin bad++; $display("FAIL fullpop_count: got %0d exp 3", bus4.count); end
    total++; if (bus4.inReady !== 1'b1) begin bad++; $display("FAIL fullpop_inReady: got %b exp 1", bus4.inReady); end
    total++; if (bus4.reqRID !== 11) begin bad++; $display("FAIL fullpop_head: got %0d exp 11", bus4.reqRID); end
    for (int i = 0; i < 6 && q4.size() != 0; i++) begin
      total++; if (bus4.reqRID !== q4[0].rid || bus4.reqRID === 30) begin bad++; $display("FAIL fullpop_drain: got %0d exp %0d", bus4.reqRID, q4[0].rid); end
      step4(1'b0, 1'b0, '0, 1'b0);
    end
    total++; if (bus4.count !== 0) begin bad++; $display("FAIL fullpop_empty: got %0d exp 0", bus4.count); end
  endtask

  task automatic test_wrap();
    int pushed = 0, popped = 0, cycles = 0;
    logic v, s;
    while (popped < 10 && cycles < 300) begin
      v = (pushed < 10) && ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0);
      total++; if (bus3.count !== q3.size() || bus3.count > 3) begin bad++; $display("FAIL wrap_count: got %0d exp %0d", bus3.count, q3.size()); end
      total++; if (bus3.req !== (q3.size() != 0)) begin bad++; $display("FAIL wrap_req: got %b exp %b", bus3.req, q3.size() != 0); end
      if (q3.size() != 0 && !s) begin
        total++; if (bus3.reqRID !== popped || bus3.reqDataVec !== q3[0].data) begin bad++; $display("FAIL wrap_order: got rid %0d exp %0d", bus3.reqRID, popped); end
        popped++;
      end
      if (v && q3.size() < 3) begin
        step3(1'b1, mk(pushed, pushed, rnd64()), s);
        pushed++;
      end else begin
        step3(v, mk(31, 63, rnd64()), s);
      end
      cycles++;
    end
    total++; if (popped != 10) begin bad++; $display("FAIL wrap_timeout: got %0d pops exp 10", popped); end
    while (q3.size() != 0 && cycles < 320) begin step3(1'b0, '0, 1'b0); cycles++; end
    total++; if (bus3.count !== 0) begin bad++; $display("FAIL wrap_empty: got %0d exp 0", bus3.count); end
  endtask

  task automatic test_mid_reset();
    step4(1'b0, 1'b1, mk(1, 40, rnd64()), 1'b1);
    step4(1'b0, 1'b1, mk(2, 41, rnd64()), 1'b1);
    total++; if (bus4.count !== 2) begin bad++; $display("FAIL midrst_pre: got %0d exp 2", bus4.count); end
    step4(1'b1, 1'b1, mk(3, 33, rnd64()), 1'b1);
    total++; if (bus4.count !== 0 || bus4.req !== 1'b0) begin bad++; $display("FAIL midrst_clear: got count %0d req %b exp 0 0", bus4.count, bus4.req); end
    total++; if (bus4.inReady !== 1'b1 || bus4.almostFull !== 1'b0) begin bad++; $display("FAIL midrst_status: got inReady %b almostFull %b exp 1 0", bus4.inReady, bus4.almostFull); end
    for (int i = 0; i < 3; i++) begin
      step4(1'b0, 1'b0, '0, 1'b0);
      total++; if (bus4.req !== 1'b0) begin bad++; $display("FAIL midrst_ghost: got req %b rid %0d exp 0", bus4.req, bus4.reqRID); end
    end
    step4(1'b0, 1'b1, mk(4, 50, rnd64()), 1'b1);
    total++; if (bus4.count !== 1 || bus4.reqRID !== 50) begin bad++; $display("FAIL midrst_after: got count %0d rid %0d exp 1 50", bus4.count, bus4.reqRID); end
    step4(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus4.inValid = 1'b0; bus4.inVRegIdx = '0; bus4.inRID = '0; bus4.inDataVec = '0; bus4.stall = 1'b1;
    bus3.inValid = 1'b0; bus3.inVRegIdx = '0; bus3.inRID = '0; bus3.inDataVec = '0; bus3.stall = 1'b1;
    @(negedge clk);
    test_reset();
    test_fill();
    test_streaming();
    test_full_pop();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
